button_event_gen: RTL and testbench



---
 rtl/button_pkg.sv | 19 +
 rtl/debounce_core.sv | 56 +++++
 rtl/button_event_gen.sv | 109 ++++++++++
 tb/tb_button_event_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and board defaults for push-button conditioning; no logic, no latency.
// Width helper sizes counters so they hold their terminal value without wrapping.
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEATING = 2'd2
   } rep_state_t;

   localparam int BTN_DEBOUNCE_DEFAULT     = 65536;
   localparam int BTN_REPEAT_DELAY_DEFAULT = 12_500_000;
   localparam int BTN_REPEAT_RATE_DEFAULT  = 2_500_000;

   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_core.sv
// Synchronizer + debounce: btn_state/btn_down/btn_up change DEBOUNCE_CYCLES+1 edges after a clean change is sampled.
// No backpressure; press_evt/release_evt flag the acceptance one cycle early so the repeat FSM can align with btn_down/btn_up.
module debounce_core
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_state,
   output logic btn_down,
   output logic btn_up,
   output logic press_evt,
   output logic release_evt
);

   localparam int             DW    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DTERM = DW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [DW-1:0] dcnt;
   logic          accept;

   assign accept      = (s2 != btn_state) && (dcnt == DTERM);
   assign press_evt   = accept && !btn_state;
   assign release_evt = accept && btn_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         dcnt      <= '0;
         btn_state <= 1'b0;
         btn_down  <= 1'b0;
         btn_up    <= 1'b0;
      end else begin
         s1       <= btn_in ^ ACTIVE_LOW;
         s2       <= s1;
         btn_down <= press_evt;
         btn_up   <= release_evt;
         // Any return to the accepted level throws away the partial count.
         if (s2 == btn_state) begin
            dcnt <= '0;
         end else if (accept) begin
            dcnt      <= '0;
            btn_state <= ~btn_state;
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/button_event_gen.sv
// Button events: debounced level, press/release pulses and auto-repeat train; repeat pulse aligned with btn_down.
// No backpressure; release always beats a coincident repeat terminal count.
module button_event_gen
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_RATE     = BTN_REPEAT_RATE_DEFAULT,
   parameter bit REPEAT_EN       = 1'b1,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_state,
   output logic btn_down,
   output logic btn_up,
   output logic btn_repeat,
   output logic btn_held_long
);

   localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int            RW         = cnt_width(RMAX);
   localparam logic [RW-1:0] DELAY_TERM = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_TERM  = RW'(REPEAT_RATE - 1);

   rep_state_t    state;
   rep_state_t    state_nxt;
   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_nxt;
   logic          repeat_nxt;
   logic          press_evt;
   logic          release_evt;

   debounce_core #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_state  (btn_state),
      .btn_down   (btn_down),
      .btn_up     (btn_up),
      .press_evt  (press_evt),
      .release_evt(release_evt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RELEASED;
         rcnt       <= '0;
         btn_repeat <= 1'b0;
      end else begin
         state      <= state_nxt;
         rcnt       <= rcnt_nxt;
         btn_repeat <= repeat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RELEASED:  if (press_evt) state_nxt = HOLD_WAIT;
         HOLD_WAIT: begin
            if (release_evt)                            state_nxt = RELEASED;
            else if (REPEAT_EN && (rcnt == DELAY_TERM)) state_nxt = REPEATING;
         end
         REPEATING: if (release_evt) state_nxt = RELEASED;
         default:   state_nxt = RELEASED;
      endcase
   end

   // Computes next-cycle values of the registered repeat pulse and its counter.
   always_comb begin
      repeat_nxt = 1'b0;
      rcnt_nxt   = rcnt;
      case (state)
         RELEASED: begin
            rcnt_nxt   = '0;
            repeat_nxt = press_evt;
         end
         HOLD_WAIT: begin
            if (release_evt || !REPEAT_EN) begin
               rcnt_nxt = '0;
            end else if (rcnt == DELAY_TERM) begin
               rcnt_nxt   = '0;
               repeat_nxt = 1'b1;
            end else begin
               rcnt_nxt = rcnt + RW'(1);
            end
         end
         REPEATING: begin
            if (release_evt) begin
               rcnt_nxt = '0;
            end else if (rcnt == RATE_TERM) begin
               rcnt_nxt   = '0;
               repeat_nxt = 1'b1;
            end else begin
               rcnt_nxt = rcnt + RW'(1);
            end
         end
         default: rcnt_nxt = '0;
      endcase
   end

   assign btn_held_long = (state == REPEATING);

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench: table of per-edge vectors for the active-high instance, then a hand-written
// sequence for an ACTIVE_LOW/no-repeat instance.
module tb_button_event_gen;

   logic clk;
   logic rst;
   logic btn_in;
   logic btn_al;

   logic btn_state, btn_down, btn_up, btn_repeat, btn_held_long;
   logic al_state, al_down, al_up, al_repeat, al_held_long;

   int n_chk  = 0;
   int n_fail = 0;

   button_event_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .btn_state(btn_state), .btn_down(btn_down), .btn_up(btn_up),
      .btn_repeat(btn_repeat), .btn_held_long(btn_held_long)
   );

   button_event_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
   ) dut_al (
      .clk(clk), .rst(rst), .btn_in(btn_al),
      .btn_state(al_state), .btn_down(al_down), .btn_up(al_up),
      .btn_repeat(al_repeat), .btn_held_long(al_held_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   ph;
      int   e;
      logic rst;
      logic btn;
      logic st;
      logic dn;
      logic up;
      logic rp;
      logic hl;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int ph, input int e, input logic r, input logic b,
                      input logic st, input logic dn, input logic up, input logic rp, input logic hl);
      vec_t v;
      v.ph = ph; v.e = e; v.rst = r; v.btn = b;
      v.st = st; v.dn = dn; v.up = up; v.rp = rp; v.hl = hl;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int ph, input int e, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s phase %0d edge %0d: got %b expected %b", nm, ph, e, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      int dn_cnt, rp_cnt, up_cnt, dn_at, rp_ne_dn, hl_seen, st_final;

      rst    = 1'b1;
      btn_in = 1'b0;
      btn_al = 1'b1;

      // Phase 0: reset, then idle.
      for (int e = 0; e < 2; e++) add(0, e, 1'b1, 1'b0, 0, 0, 0, 0, 0);
      for (int e = 2; e < 4; e++) add(0, e, 1'b0, 1'b0, 0, 0, 0, 0, 0);

      // Phase 1: 3-cycle glitch is one short of acceptance.
      for (int e = 0; e < 3;  e++) add(1, e, 1'b0, 1'b1, 0, 0, 0, 0, 0);
      for (int e = 3; e < 11; e++) add(1, e, 1'b0, 1'b0, 0, 0, 0, 0, 0);

      // Phase 2: clean press at edge 0, release sampled at 22 lands on the 27 repeat slot.
      for (int e = 0; e <= 32; e++)
         add(2, e, 1'b0, e < 22,
             (e >= 5) && (e < 27), e == 5, e == 27,
             e inside {5, 15, 18, 21, 24},
             (e >= 15) && (e < 27));

      // Phase 3: bounce, final toggle at 12; reset at 32..33 while held; re-press; release at 43.
      for (int e = 0; e <= 50; e++)
         add(3, e, (e == 32) || (e == 33),
             (e < 12) ? ((e % 4) < 2) : (e < 43),
             ((e >= 17) && (e < 32)) || ((e >= 39) && (e < 48)),
             (e == 17) || (e == 39), e == 48,
             e inside {17, 27, 30, 39},
             (e >= 27) && (e < 32));

      foreach (tbl[i]) begin
         rst    = tbl[i].rst;
         btn_in = tbl[i].btn;
         @(posedge clk);
         #1;
         chk("btn_state",     tbl[i].ph, tbl[i].e, btn_state,     tbl[i].st);
         chk("btn_down",      tbl[i].ph, tbl[i].e, btn_down,      tbl[i].dn);
         chk("btn_up",        tbl[i].ph, tbl[i].e, btn_up,        tbl[i].up);
         chk("btn_repeat",    tbl[i].ph, tbl[i].e, btn_repeat,    tbl[i].rp);
         chk("btn_held_long", tbl[i].ph, tbl[i].e, btn_held_long, tbl[i].hl);
         chk("al_idle_state", tbl[i].ph, tbl[i].e, al_state,      1'b0);
      end

      // Phase 4: active-low pin held low 30 cycles, no auto-repeat.
      rst = 1'b0; btn_in = 1'b0;
      dn_cnt = 0; rp_cnt = 0; up_cnt = 0; dn_at = -1; rp_ne_dn = 0; hl_seen = 0;
      btn_al = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (al_down) begin dn_cnt++; dn_at = c; end
         if (al_repeat) rp_cnt++;
         if (al_repeat !== al_down) rp_ne_dn++;
         if (al_held_long) hl_seen++;
      end
      st_final = al_state;
      chk_int("al_down_count",      dn_cnt,   1);
      chk_int("al_down_edge",       dn_at,    5);
      chk_int("al_repeat_count",    rp_cnt,   1);
      chk_int("al_repeat_vs_down",  rp_ne_dn, 0);
      chk_int("al_held_long_cycles", hl_seen, 0);
      chk_int("al_state_held",      st_final, 1);

      btn_al = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (al_up) up_cnt++;
         if (al_repeat) rp_cnt++;
      end
      chk_int("al_up_count",         up_cnt,   1);
      chk_int("al_repeat_after_rel", rp_cnt,   1);
      chk_int("al_state_released",   al_state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
